spike_encoder: RTL and testbench

- Temporal (time-to-first-spike) encoder that produces the spike volleys consumed by the neuron accumulator's `spikes_in` bus.
- Accepts one vector of N input intensities through a valid/ready handshake.
- Over a fixed window of 2^TBITS cycles it emits at most one single-cycle spike per lane: brighter input means an earlier spike.
- Sits between the input-pixel source and the neuron layer.

---
 rtl/spike_pkg.sv | 56 +++++
 rtl/spike_encoder_lane.sv | 61 ++++++
 rtl/spike_encoder.sv | 130 +++++++++++++
 tb/tb_spike_encoder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/spike_pkg.sv
//------------------------------------------------------------------------------
// Module   : spike_pkg
// Purpose  : Shared types and helpers for the time-to-first-spike encoder.
//            Provides the encoder state type, the lane count default, the
//            default spike window and the intensity-to-slot quantiser.
// Ports    : none (package)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef NUM_SPIKES
`define NUM_SPIKES 4
`endif

package spike_pkg;

  // Default lane count comes from the project-wide define.
  localparam int NUM_LANES     = `NUM_SPIKES;

  // Default geometry; the window is always a power of two of the slot bits.
  localparam int VBITS_DEFAULT = 8;
  localparam int TBITS_DEFAULT = 3;
  localparam int WIN           = 1 << TBITS_DEFAULT;

  // Working width of the quantiser; wide enough for any legal VBITS.
  localparam int QW            = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } enc_state_t;

  typedef struct packed {
    logic          enable;
    logic [QW-1:0] slot;
  } quant_t;

  // Keeps the top TBITS of the intensity. A zero level disables the lane;
  // any other level maps to slot (WIN-1)-q, so brighter inputs fire earlier
  // and slot WIN-1 is never used for a spike.
  function automatic quant_t quantize(input logic [QW-1:0] val,
                                      input int            vbits,
                                      input int            tbits);
    logic [QW-1:0] mask;
    logic [QW-1:0] q;
    quant_t        r;
    mask     = (QW'(1) << tbits) - QW'(1);
    q        = (val >> (vbits - tbits)) & mask;
    r.enable = |q;
    r.slot   = mask - q;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spike_encoder_lane.sv
//------------------------------------------------------------------------------
// Module   : spike_lane
// Purpose  : One encoder lane. Captures the quantised spike slot and enable
//            bit on the accept strobe and fires a single-cycle spike when the
//            shared slot counter reaches the captured slot.
// Ports    : clk, rst_n      - clock, asynchronous active-low reset
//            load            - accept strobe from the top-level handshake
//            clear           - synchronous abort, drops the enable
//            val             - raw lane intensity
//            cnt, run        - shared slot counter and volley-active flag
//            spike           - spike pulse for this lane
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module spike_lane
  import spike_pkg::*;
#(
  parameter int VBITS = 8,
  parameter int TBITS = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic [VBITS-1:0] val,
  input  logic [TBITS-1:0] cnt,
  input  logic             run,
  output logic             spike
);

  quant_t           w_quant;
  logic [TBITS-1:0] w_slot;
  logic             w_unused_slot_bits;
  logic             r_enable;
  logic [TBITS-1:0] r_slot;

  assign w_quant = quantize(QW'(val), VBITS, TBITS);
  assign w_slot  = w_quant.slot[TBITS-1:0];

  // Upper quantiser bits are always zero for a TBITS-wide slot.
  assign w_unused_slot_bits = ^w_quant.slot[QW-1:TBITS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enable <= 1'b0;
      r_slot   <= '0;
    end else if (clear) begin
      r_enable <= 1'b0;
      r_slot   <= '0;
    end else if (load) begin
      r_enable <= w_quant.enable;
      r_slot   <= w_slot;
    end
  end

  assign spike = run & r_enable & (cnt == r_slot);

endmodule

`default_nettype wire

// File: rtl/spike_encoder.sv
//------------------------------------------------------------------------------
// Module   : spike_encoder
// Purpose  : Time-to-first-spike encoder. Accepts one vector of N intensities
//            per volley and emits at most one spike per lane inside a window
//            of 2^TBITS cycles; brighter lanes spike earlier.
// Ports    : clk, rst_n      - clock, asynchronous active-low reset
//            in_valid/ready  - input vector handshake
//            in_vals         - lane intensities, lane i on index i
//            clear           - synchronous abort of the current volley
//            spikes_out      - per-lane spike pulses
//            frame_start     - pulses in slot 0 of each volley
//            frame_done      - pulses in slot WIN-1 of each volley
//            busy            - volley in progress
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module spike_encoder
  import spike_pkg::*;
#(
  parameter int N     = NUM_LANES,
  parameter int VBITS = 8,
  parameter int TBITS = 3       // legal range 1..VBITS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [N-1:0][VBITS-1:0]   in_vals,
  output logic                      in_ready,
  input  logic                      clear,
  output logic [N-1:0]              spikes_out,
  output logic                      frame_start,
  output logic                      frame_done,
  output logic                      busy
);

  localparam logic [TBITS-1:0] C_LAST = {TBITS{1'b1}};

  enc_state_t       r_state;
  enc_state_t       w_state_nxt;
  logic [TBITS-1:0] r_cnt;
  logic [TBITS-1:0] w_cnt_nxt;
  logic             r_alive;
  logic             w_run;
  logic             w_last;
  logic             w_accept;

  // Holds in_ready low while in reset and releases it on the first edge
  // after deassertion, independent of the state register's IDLE value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alive <= 1'b0;
    end else begin
      r_alive <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign w_run    = (r_state == RUN);
  assign w_last   = (r_cnt == C_LAST);
  assign in_ready = r_alive & (~w_run | w_last);

  // clear outranks a simultaneous handshake.
  assign w_accept = in_valid & in_ready & ~clear;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (clear) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            w_state_nxt = RUN;
            w_cnt_nxt   = '0;
          end
        end
        RUN: begin
          if (w_last) begin
            // Back-to-back accept restarts the window with no idle gap.
            w_state_nxt = w_accept ? RUN : IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign frame_start = w_run & (r_cnt == '0);
  assign frame_done  = w_run & w_last;
  assign busy        = w_run;

  generate
    for (genvar i = 0; i < N; i++) begin : g_lane
      spike_lane #(
        .VBITS (VBITS),
        .TBITS (TBITS)
      ) u_lane (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_accept),
        .clear (clear),
        .val   (in_vals[i]),
        .cnt   (r_cnt),
        .run   (w_run),
        .spike (spikes_out[i])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_spike_encoder.sv
//------------------------------------------------------------------------------
// Module   : tb_spike_encoder
// Purpose  : Self-checking bench for spike_encoder (N=4, VBITS=8, TBITS=3).
//            Directed volleys followed by randomized traffic, all checked
//            against a slot-level reference model of the encoder.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_spike_encoder;

  localparam int N     = 4;
  localparam int VBITS = 8;
  localparam int TBITS = 3;
  localparam int WIN   = 8;

  localparam logic [N-1:0][VBITS-1:0] C_BASIC = {8'd32, 8'd31, 8'd128, 8'd255};
  localparam logic [N-1:0][VBITS-1:0] C_B2B   = {8'd224, 8'd224, 8'd224, 8'd224};
  localparam logic [N-1:0][VBITS-1:0] C_ZERO  = {8'd0, 8'd0, 8'd0, 8'd0};
  localparam logic [N-1:0][VBITS-1:0] C_DIM   = {8'd31, 8'd31, 8'd31, 8'd31};

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    in_valid = 1'b0;
  logic [N-1:0][VBITS-1:0] in_vals = '0;
  logic                    clear = 1'b0;
  logic                    in_ready;
  logic [N-1:0]            spikes_out;
  logic                    frame_start;
  logic                    frame_done;
  logic                    busy;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: is the encoder out of reset, is a volley running,
  // which slot of the window are we in, and each lane's firing time.
  bit m_alive  = 1'b0;
  bit m_active = 1'b0;
  int m_slot   = 0;
  int m_fire[N];
  bit m_en[N];

  spike_encoder #(
    .N     (N),
    .VBITS (VBITS),
    .TBITS (TBITS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_vals     (in_vals),
    .in_ready    (in_ready),
    .clear       (clear),
    .spikes_out  (spikes_out),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] exp_sp;
    bit           exp_rdy;
    exp_sp = '0;
    for (int i = 0; i < N; i++) begin
      if (m_active && m_en[i] && (m_fire[i] == m_slot)) exp_sp[i] = 1'b1;
    end
    exp_rdy = m_alive && (!m_active || (m_slot == WIN - 1));
    chk("spikes_out",  32'(spikes_out),  32'(exp_sp));
    chk("frame_start", 32'(frame_start), 32'(m_active && (m_slot == 0)));
    chk("frame_done",  32'(frame_done),  32'(m_active && (m_slot == WIN - 1)));
    chk("busy",        32'(busy),        32'(m_active));
    chk("in_ready",    32'(in_ready),    32'(exp_rdy));
  endtask

  // Advances the model across one rising edge with the given inputs.
  task automatic model_next(input bit v, input logic [N-1:0][VBITS-1:0] vals, input bit clr);
    bit rdy;
    bit acc;
    int level;
    rdy = m_alive && (!m_active || (m_slot == WIN - 1));
    acc = v && rdy && !clr;
    if (!m_alive) begin
      m_alive = 1'b1;
    end else if (clr) begin
      m_active = 1'b0;
      m_slot   = 0;
      for (int i = 0; i < N; i++) m_en[i] = 1'b0;
    end else if (acc) begin
      m_active = 1'b1;
      m_slot   = 0;
      for (int i = 0; i < N; i++) begin
        level     = int'(vals[i]) / 32;   // top 3 of 8 bits
        m_en[i]   = (level != 0);
        m_fire[i] = (WIN - 1) - level;
      end
    end else if (m_active) begin
      if (m_slot == WIN - 1) begin
        m_active = 1'b0;
        m_slot   = 0;
      end else begin
        m_slot++;
      end
    end
  endtask

  // One clock cycle: check at the falling edge, then drive the next inputs.
  task automatic cycle(input bit v, input logic [N-1:0][VBITS-1:0] vals, input bit clr);
    check_outputs();
    in_valid = v;
    in_vals  = vals;
    clear    = clr;
    model_next(v, vals, clr);
    @(negedge clk);
  endtask

  function automatic logic [N-1:0][VBITS-1:0] rnd_vals();
    logic [31:0] r;
    r = $urandom;
    return r;
  endfunction

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, rnd_vals(), 1'b0);
  endtask

  // Asynchronous reset asserted between edges; outputs must drop at once.
  task automatic mid_reset();
    check_outputs();
    in_valid = 1'b0;
    clear    = 1'b0;
    #2;
    rst_n    = 1'b0;
    m_alive  = 1'b0;
    m_active = 1'b0;
    m_slot   = 0;
    for (int i = 0; i < N; i++) m_en[i] = 1'b0;
    #1;
    check_outputs();
    @(negedge clk);
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      m_fire[i] = 0;
      m_en[i]   = 1'b0;
    end

    // Reset state
    @(negedge clk);
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Basic volley
    cycle(1'b1, C_BASIC, 1'b0);
    idle(10);

    // Back-to-back: valid held through the whole first volley
    cycle(1'b1, C_BASIC, 1'b0);
    for (int k = 0; k < WIN; k++) cycle(1'b1, C_B2B, 1'b0);
    idle(10);

    // Abort at slot 2
    cycle(1'b1, C_BASIC, 1'b0);
    idle(2);
    cycle(1'b0, rnd_vals(), 1'b1);
    idle(8);

    // Clear in IDLE alongside a valid vector: no accept
    cycle(1'b1, C_BASIC, 1'b1);
    idle(3);

    // Async reset at slot 4
    cycle(1'b1, C_BASIC, 1'b0);
    idle(4);
    mid_reset();
    idle(10);

    // Boundaries: all-zero and all-31 vectors never spike
    cycle(1'b1, C_ZERO, 1'b0);
    idle(9);
    cycle(1'b1, C_DIM, 1'b0);
    idle(9);

    // Handshake hold-off: valid during slots 1..6 must be ignored
    cycle(1'b1, C_BASIC, 1'b0);
    idle(1);
    for (int k = 0; k < 6; k++) cycle(1'b1, rnd_vals(), 1'b0);
    idle(3);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 599) == 0) begin
        mid_reset();
      end else begin
        cycle($urandom_range(0, 9) < 3, rnd_vals(), $urandom_range(0, 31) == 0);
      end
    end
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
